// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. Computes {borrow, diff} = a - b - bin,
// one bit per clock, LSB first. The operation takes WIDTH cycles in RUN and
// then one DONE cycle that carries the done pulse.
//
// Parameters
//   WIDTH   operand width in bits (2..64), default 8
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset, has priority over start
//   start   operation request, only sampled while idle
//   a       minuend, captured when start is accepted
//   b       subtrahend, captured when start is accepted
//   bin     borrow-in, captured when start is accepted
//   busy    high while in RUN or DONE
//   done    one-cycle completion pulse (registered)
//   diff    result difference (registered, updated only on entering DONE)
//   borrow  result borrow-out (registered, updated only on entering DONE)
//   ovf     signed overflow flag, present only when the macro
//           SERIAL_SUBTRACTOR_OVF_EN is defined
//
// Build option
//   SERIAL_SUBTRACTOR_OVF_EN  adds the ovf output and its register
//
// States
//   state | meaning
//   IDLE  | waiting for start; outputs hold last result
//   RUN   | resolving one difference bit per clock, LSB first
//   DONE  | result valid and done pulsed for this one cycle
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             borrow,
  output logic             ovf
`else
  output logic             borrow
`endif
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    idx;
  logic             br;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] acc_nxt;

  // Current bit slice: operands shift right so bit 0 is always the bit
  // being resolved.
  assign a_bit   = a_sh[0];
  assign b_bit   = b_sh[0];
  assign d_bit   = a_bit ^ b_bit ^ br;
  assign br_nxt  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  // New bits enter at the MSB; after WIDTH shifts bit 0 of the result has
  // walked down to position 0.
  assign acc_nxt = {d_bit, acc[WIDTH-1:1]};

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      idx    <= '0;
      br     <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            acc   <= '0;
            idx   <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nxt;
          acc  <= acc_nxt;
          if (idx == LAST_IDX) begin
            diff   <= acc_nxt;
            borrow <= br_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            // On the last bit the shifters hold the operand MSBs and d_bit
            // is the result MSB, so no copy of the operands is needed.
            ovf    <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
`endif
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed and randomised checks of serial_subtractor at WIDTH=8. Inputs are
// driven 1 time unit after a rising edge, outputs are sampled at the same
// point. Build with SERIAL_SUBTRACTOR_OVF_EN defined to also check ovf.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .borrow (borrow),
    .ovf    (ovf)
`else
    .borrow (borrow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation on the next edge and checks latency and result.
  // Entered and left 1 unit after an edge, with the DUT idle at the next edge.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                       input logic [W-1:0] ed, input logic eb, input logic eo,
                       input string tag);
    int lat;
    a     = ta;
    b     = tb_;
    bin   = tbin;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = ~ta;
    b     = ~tb_;
    bin   = ~tbin;
    check({tag, ".busy_run"}, busy, 1'b1);
    lat = 0;
    for (int n = 1; n <= 2 * W; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    check({tag, ".latency"}, lat, W);
    check({tag, ".diff"}, diff, ed);
    check({tag, ".borrow"}, borrow, eb);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check({tag, ".ovf"}, ovf, eo);
`else
    if (eo) begin end
`endif
    tick();
    check({tag, ".done_clr"}, done, 1'b0);
    check({tag, ".busy_clr"}, busy, 1'b0);
  endtask

  initial begin
    int lat;
    logic saw_done;
    logic [W-1:0] ra, rb;
    logic         rbin;
    logic [W:0]   r;

    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    bin   = 1'b1;
    repeat (3) tick();
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.diff", diff, 8'h00);
    check("rst.borrow", borrow, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("rst.ovf", ovf, 1'b0);
`endif
    start = 1'b0;
    rst   = 1'b0;
    tick();

    do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "op05_03");
    do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "op00_01");
    do_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, "op80_7F_b");
    do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "op7F_FF");

    // Start raised again mid-run with different operands must be ignored.
    a     = 8'h3C;
    b     = 8'h15;
    bin   = 1'b0;
    start = 1'b1;
    tick();                 // edge k
    start = 1'b0;
    tick();                 // k+1
    tick();                 // k+2
    check("ign.diff_hold", diff, 8'h80);
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    tick();                 // k+3
    start = 1'b0;
    check("ign.busy", busy, 1'b1);
    lat = 0;
    for (int n = 4; n <= 2 * W; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    check("ign.latency", lat, W);
    check("ign.diff", diff, 8'h27);
    check("ign.borrow", borrow, 1'b0);
    tick();
    check("ign.done_clr", done, 1'b0);
    check("ign.busy_clr", busy, 1'b0);
    tick();
    check("ign.no_restart", busy, 1'b0);

    // Reset at edge k+4 aborts the operation.
    a     = 8'h10;
    b     = 8'h01;
    bin   = 1'b0;
    start = 1'b1;
    tick();                 // edge k
    start = 1'b0;
    tick();                 // k+1
    tick();                 // k+2
    tick();                 // k+3
    rst = 1'b1;
    tick();                 // k+4
    rst = 1'b0;
    check("abort.busy", busy, 1'b0);
    check("abort.done", done, 1'b0);
    check("abort.diff", diff, 8'h00);
    check("abort.borrow", borrow, 1'b0);
    saw_done = 1'b0;
    for (int n = 0; n < 2 * W; n++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("abort.no_done", saw_done, 1'b0);
    do_op(8'h20, 8'h30, 1'b1, 8'hEF, 1'b1, 1'b0, "after_abort");

    // Back-to-back random operations against the arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      r    = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      do_op(ra, rb, rbin, r[W-1:0], r[W],
            (ra[W-1] ^ rb[W-1]) & (ra[W-1] ^ r[W-1]), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits; legal range 2..64.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only when idle.
REQ-005 SHALL have port: a  input  WIDTH  minuend, captured on accepted start.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend, captured on accepted start.
REQ-007 SHALL have port: bin  input  1  borrow-in, captured on accepted start.
REQ-008 SHALL have port: busy  output  1  high in RUN and DONE states.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse, registered.
REQ-010 SHALL have port: diff  output  WIDTH  result difference, registered.
REQ-011 SHALL have port: borrow  output  1  result borrow-out, registered.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; every output is a register or decoded from registered state.
REQ-013 SHALL, in IDLE with start=1 at edge k: capture a, b, bin; clear bit index; go to RUN.
REQ-014 SHALL, in RUN, resolve one bit per edge, LSB first: d=a_i^b_i^br; br'=(~a_i&b_i)|(~(a_i^b_i)&br); br initialised to bin.
REQ-015 SHALL leave RUN for DONE at the edge resolving bit WIDTH-1, i.e. edge k+WIDTH.
REQ-016 SHALL update diff and borrow only at the edge entering DONE; both hold their values otherwise.
REQ-017 SHALL assert done exactly during the DONE cycle (edge k+WIDTH to k+WIDTH+1), then return to IDLE.
REQ-018 SHALL produce {borrow,diff} = (a - b - bin) mod 2^(WIDTH+1); borrow=1 iff a < b+bin, unsigned.
REQ-019 SHALL ignore start in RUN and DONE; captured operands are unaffected by input changes after capture.
REQ-020 SHALL allow a new start in the first IDLE cycle after DONE; minimum start-to-start spacing WIDTH+2 cycles.
REQ-021 SHALL use a bit-index counter of clog2(WIDTH) bits with no wrap beyond WIDTH-1.

Reset
REQ-022 SHALL, with rst=1 at an edge, force state IDLE, busy=0, done=0, diff=0, borrow=0, internal registers 0.
REQ-023 SHALL give rst priority over start; rst mid-RUN aborts the operation with no done pulse and no result update.

Configuration
REQ-024 SHALL, with SERIAL_SUBTRACTOR_OVF_EN defined, add port ovf  output  1  signed overflow, =(a[W-1]^b[W-1])&(a[W-1]^diff[W-1]), updated with diff, reset 0.
REQ-025 SHALL, without SERIAL_SUBTRACTOR_OVF_EN, omit port ovf and all associated logic; other behaviour identical.

Verification (WIDTH=8)
REQ-026 SHALL check a=0x05, b=0x03, bin=0, start at edge k -> done only at edge k+8, diff=0x02, borrow=0.
REQ-027 SHALL check a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow=1; ovf=0 when enabled.
REQ-028 SHALL check a=0x80, b=0x7F, bin=1 -> diff=0x00, borrow=0; ovf=1 when enabled.
REQ-029 SHALL check second start with a=0xFF, b=0x00 at edge k+3 -> ignored; result matches first operation; busy stays 1.
REQ-030 SHALL check rst=1 at edge k+4 -> busy=0, diff=0, borrow=0, no done pulse; next start completes correctly.
REQ-031 SHALL check 1000 random back-to-back operations, both macro settings -> all match (a-b-bin) reference model.
